axil_cfg_master: RTL and testbench

AXIL_CFG_MASTER -- requirements
Module: axil_cfg_master

---
 rtl/global_buffer_param.sv | 23 ++
 rtl/axil_cfg_master_if.sv | 36 +++
 rtl/axil_cfg_master.sv | 182 ++++++++++++++++++
 tb/tb_axil_cfg_master.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_buffer_param.sv
// Shared AXI4-Lite widths and enumerations for the global-buffer configuration path.
package global_buffer_param;

    localparam int CGRA_AXI_ADDR_WIDTH = 12;
    localparam int CGRA_AXI_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } axil_master_state_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

endpackage

// File: rtl/axil_cfg_master_if.sv
// AXI4-Lite bus between the configuration master and a Garnet-style slave.
interface axil_cfg_master_if
    import global_buffer_param::*;
#(
    parameter int ADDR_WIDTH = CGRA_AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = CGRA_AXI_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite master turning cmd/rsp requests into bus transactions,
// with a per-transaction cycle budget that aborts stuck accesses with SLVERR.
module axil_cfg_master
    import global_buffer_param::*;
#(
    parameter int ADDR_WIDTH = CGRA_AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = CGRA_AXI_DATA_WIDTH,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    output logic                  busy,

    axil_cfg_master_if.master     axi
);

    localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    axil_master_state_e    state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  arvalid_q;
    logic                  bready_q;
    logic                  rready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic                  rsp_timeout_q;

    logic                  aw_pend;
    logic                  w_pend;
    logic                  in_flight;
    logic                  progress;
    logic                  abort;

    // A transaction that completes on the same edge the budget runs out still completes.
    always_comb begin
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        aw_pend   = awvalid_q && !axi.awready;
        w_pend    = wvalid_q && !axi.wready;
        in_flight = 1'b0;
        progress  = 1'b0;
        case (state_q)
            WR_REQ:  begin in_flight = 1'b1; progress = !aw_pend && !w_pend; end
            WR_RESP: begin in_flight = 1'b1; progress = axi.bvalid;          end
            RD_REQ:  begin in_flight = 1'b1; progress = axi.arready;         end
            RD_RESP: begin in_flight = 1'b1; progress = axi.rvalid;          end
            default: begin in_flight = 1'b0; progress = 1'b0;                end
        endcase
        abort = in_flight && !progress && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else if (abort) begin
            state_q       <= RSP;
            cnt_q         <= cnt_d;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= SLVERR;
            rsp_timeout_q <= 1'b1;
        end else begin
            if (in_flight) begin
                cnt_q <= cnt_d;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cnt_q   <= '0;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                // AW and W retire independently; each valid falls right after its own handshake.
                WR_REQ: begin
                    awvalid_q <= aw_pend;
                    wvalid_q  <= w_pend;
                    if (!aw_pend && !w_pend) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= axi.bresp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RSP;
                    end
                end
                RD_REQ: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi.rvalid) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= axi.rdata;
                        rsp_resp_q    <= axi.rresp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    assign axi.awaddr  = addr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: a delay-planned AXI4-Lite slave plus a transaction-level
// reference that predicts each response and its latency from the planned delays.
module tb_axil_cfg_master;
    import global_buffer_param::*;

    localparam int AW = CGRA_AXI_ADDR_WIDTH;
    localparam int DW = CGRA_AXI_DATA_WIDTH;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic          busy;

    axil_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axil_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Slave plan for the current transaction; a negative delay means "never".
    int            p_aw_dly, p_w_dly, p_ar_dly, p_b_dly, p_r_dly, p_hold;
    logic [1:0]    p_bresp, p_rresp;
    logic [DW-1:0] p_rdata;

    bit            t_write;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;

    bit            active = 1'b0;
    bit            aw_done, w_done, ar_done, b_sent, r_sent, rsp_seen, rsp_done;
    int            aw_wait, w_wait, ar_wait, b_wait, r_wait, hold_cnt;
    int            aw_hs, w_hs, ar_hs, b_hs, r_hs, accept_cyc;

    logic [DW-1:0] e_rdata;
    logic [1:0]    e_resp;
    logic          e_to;
    int            e_lat;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_resp;
    logic          s_to;

    logic          prev_awv = 1'b0, prev_awr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0;
    logic          prev_arv = 1'b0, prev_arr = 1'b0;
    logic [AW-1:0] prev_awaddr = '0, prev_araddr = '0;
    logic [DW-1:0] prev_wdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called once per negedge: check DUT outputs, then drive slave inputs and rsp_ready.
    task automatic step();
        bit abort_now;
        abort_now = rsp_valid && rsp_timeout;

        chk("busy", 64'(busy), 64'(active));
        chk("cmd_ready", 64'(cmd_ready), 64'(!active));
        if (!active) begin
            chk("idle_axi_handshakes",
                64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'(0));
            chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        end

        if (prev_awv && !prev_awr && !abort_now) begin
            chk("awvalid_held", 64'(axi.awvalid), 64'(1));
            chk("awaddr_stable", 64'(axi.awaddr), 64'(prev_awaddr));
        end
        if (prev_wv && !prev_wr && !abort_now) begin
            chk("wvalid_held", 64'(axi.wvalid), 64'(1));
            chk("wdata_stable", 64'(axi.wdata), 64'(prev_wdata));
        end
        if (prev_arv && !prev_arr && !abort_now) begin
            chk("arvalid_held", 64'(axi.arvalid), 64'(1));
            chk("araddr_stable", 64'(axi.araddr), 64'(prev_araddr));
        end

        if (axi.awvalid) begin
            chk("aw_single", 64'(aw_done), 64'(0));
            chk("awaddr", 64'(axi.awaddr), 64'(t_addr));
            chk("aw_on_write", 64'(t_write), 64'(1));
        end
        if (axi.wvalid) begin
            chk("w_single", 64'(w_done), 64'(0));
            chk("wdata", 64'(axi.wdata), 64'(t_wdata));
        end
        if (axi.arvalid) begin
            chk("ar_single", 64'(ar_done), 64'(0));
            chk("araddr", 64'(axi.araddr), 64'(t_addr));
            chk("ar_on_read", 64'(t_write), 64'(0));
        end
        if (axi.bready) chk("bready_after_aw_w", 64'(aw_done && w_done), 64'(1));
        if (axi.rready) chk("rready_after_ar", 64'(ar_done), 64'(1));

        // Responses first, so they only follow handshakes from earlier edges.
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        if (t_write && aw_done && w_done && !b_sent && p_b_dly >= 0) begin
            if (b_wait == p_b_dly) begin
                axi.bvalid = 1'b1;
                axi.bresp  = p_bresp;
                if (axi.bready) begin b_sent = 1'b1; b_hs++; end
            end else b_wait++;
        end
        axi.rvalid = 1'b0;
        axi.rresp  = 2'b00;
        axi.rdata  = '0;
        if (!t_write && ar_done && !r_sent && p_r_dly >= 0) begin
            if (r_wait == p_r_dly) begin
                axi.rvalid = 1'b1;
                axi.rresp  = p_rresp;
                axi.rdata  = p_rdata;
                if (axi.rready) begin r_sent = 1'b1; r_hs++; end
            end else r_wait++;
        end

        axi.awready = 1'b0;
        if (axi.awvalid && !aw_done) begin
            if (aw_wait == p_aw_dly) begin axi.awready = 1'b1; aw_done = 1'b1; aw_hs++; end
            else aw_wait++;
        end
        axi.wready = 1'b0;
        if (axi.wvalid && !w_done) begin
            if (w_wait == p_w_dly) begin axi.wready = 1'b1; w_done = 1'b1; w_hs++; end
            else w_wait++;
        end
        axi.arready = 1'b0;
        if (axi.arvalid && !ar_done) begin
            if (ar_wait == p_ar_dly) begin axi.arready = 1'b1; ar_done = 1'b1; ar_hs++; end
            else ar_wait++;
        end

        rsp_ready = 1'b0;
        if (rsp_valid) begin
            chk("rsp_only_when_active", 64'(active), 64'(1));
            if (!rsp_seen) begin
                rsp_seen = 1'b1;
                s_rdata  = rsp_rdata;
                s_resp   = rsp_resp;
                s_to     = rsp_timeout;
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
                chk("rsp_resp", 64'(rsp_resp), 64'(e_resp));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
                chk("rsp_latency", 64'(cyc + 1 - accept_cyc), 64'(e_lat));
            end else begin
                chk("rsp_rdata_stable", 64'(rsp_rdata), 64'(s_rdata));
                chk("rsp_resp_stable", 64'(rsp_resp), 64'(s_resp));
                chk("rsp_timeout_stable", 64'(rsp_timeout), 64'(s_to));
            end
            if (hold_cnt >= p_hold) begin rsp_ready = 1'b1; rsp_done = 1'b1; end
            else hold_cnt++;
        end

        prev_awv = axi.awvalid; prev_awr = axi.awready; prev_awaddr = axi.awaddr;
        prev_wv  = axi.wvalid;  prev_wr  = axi.wready;  prev_wdata  = axi.wdata;
        prev_arv = axi.arvalid; prev_arr = axi.arready; prev_araddr = axi.araddr;
    endtask

    // mode 0: normal, 1: keep cmd_valid pending during the response, 2: reset in WR_RESP.
    task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int mode);
        int stall;
        t_write = wr; t_addr = a; t_wdata = d;
        aw_done = 0; w_done = 0; ar_done = 0; b_sent = 0; r_sent = 0;
        rsp_seen = 0; rsp_done = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; hold_cnt = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;

        e_rdata = '0;
        e_to    = 1'b0;
        if (wr) begin
            stall = (p_aw_dly > p_w_dly) ? p_aw_dly : p_w_dly;
            if (p_aw_dly < 0 || p_w_dly < 0 || p_b_dly < 0) begin
                e_to = 1'b1; e_resp = 2'b10; e_lat = TO;
            end else begin
                e_resp = p_bresp; e_lat = 3 + stall + p_b_dly;
            end
        end else begin
            if (p_ar_dly < 0 || p_r_dly < 0) begin
                e_to = 1'b1; e_resp = 2'b10; e_lat = TO;
            end else begin
                e_resp = p_rresp; e_rdata = p_rdata; e_lat = 3 + p_ar_dly + p_r_dly;
            end
        end

        @(negedge clk);
        step();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        accept_cyc = cyc + 1;
        active = 1'b1;

        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n == 0) begin
                cmd_addr  = AW'($urandom);
                cmd_wdata = DW'($urandom);
                if (mode != 1) cmd_valid = 1'b0;
            end
            step();
            if (mode == 2 && axi.bready) begin
                reset_n = 1'b0;
                @(negedge clk);
                active = 1'b0;
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}),
                    64'(0));
                chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("rst_rsp_fields", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'(0));
                chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
                reset_n = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    step();
                end
                return;
            end
            if (rsp_done) begin
                cmd_valid = 1'b0;
                break;
            end
        end

        if (!rsp_done) begin
            checks++; errors++;
            $display("FAIL rsp_wait: no response within 100 cycles, expected one (cycle %0d)", cyc);
            cmd_valid = 1'b0;
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            active = 1'b0;
            return;
        end
        active = 1'b0;
        chk("aw_count", 64'(aw_hs), 64'(wr ? 1 : 0));
        chk("w_count", 64'(w_hs), 64'(wr ? 1 : 0));
        chk("ar_count", 64'(ar_hs), 64'(wr ? 0 : 1));
        chk("b_count", 64'(b_hs), 64'((wr && !e_to) ? 1 : 0));
        chk("r_count", 64'(r_hs), 64'((!wr && !e_to) ? 1 : 0));
    endtask

    task automatic plan(input int aw_d, input int w_d, input int ar_d, input int b_d,
                        input int r_d, input int hold);
        p_aw_dly = aw_d; p_w_dly = w_d; p_ar_dly = ar_d;
        p_b_dly = b_d; p_r_dly = r_d; p_hold = hold;
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
        p_bresp = 2'b00; p_rresp = 2'b00; p_rdata = '0;
        plan(0, 0, 0, 0, 0, 0);
        t_write = 1'b0; t_addr = '0; t_wdata = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}),
            64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

        // Zero-wait write: response three cycles after accept.
        plan(0, 0, 0, 0, 0, 0); p_bresp = 2'b00;
        do_txn(1'b1, 12'h010, 32'hDEADBEEF, 0);
        chk("lat_zero_wait_write", 64'(e_lat), 64'(3));

        // Zero-wait read.
        plan(0, 0, 0, 0, 0, 0); p_rresp = 2'b00; p_rdata = 32'hCAFEF00D;
        do_txn(1'b0, 12'h044, 32'h0, 0);

        // Read with arready stalled five cycles.
        plan(0, 0, 5, 0, 0, 0); p_rresp = 2'b00; p_rdata = 32'h12345678;
        do_txn(1'b0, 12'h020, 32'h0, 0);
        chk("lat_ar_stall", 64'(e_lat), 64'(8));

        // awready at cycle 1, wready at cycle 4, then the reverse order.
        plan(1, 4, 0, 0, 0, 0); p_bresp = 2'b01;
        do_txn(1'b1, 12'h0A4, 32'h0BADF00D, 0);
        chk("lat_split_aw_w", 64'(e_lat), 64'(7));
        plan(3, 0, 0, 1, 0, 0); p_bresp = 2'b11;
        do_txn(1'b1, 12'h0A8, 32'h13579BDF, 0);

        // Slave never answers the write.
        plan(0, 0, 0, -1, 0, 0);
        do_txn(1'b1, 12'h0F0, 32'hA5A5A5A5, 0);
        chk("lat_timeout", 64'(e_lat), 64'(16));

        // Slave never answers the read.
        plan(0, 0, 2, 0, -1, 1);
        do_txn(1'b0, 12'h0F4, 32'h0, 0);

        // Response held ten cycles while another command waits.
        plan(0, 0, 0, 0, 0, 10); p_rresp = 2'b10; p_rdata = 32'h00C0FFEE;
        do_txn(1'b0, 12'h100, 32'h0, 1);

        // Reset while waiting for bvalid.
        plan(0, 0, 0, -1, 0, 0);
        do_txn(1'b1, 12'h200, 32'h11223344, 2);

        for (int i = 0; i < 40; i++) begin
            plan($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            p_bresp = 2'($urandom_range(0, 3));
            p_rresp = 2'($urandom_range(0, 3));
            p_rdata = DW'($urandom);
            do_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 0);
        end

        @(negedge clk);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
